// File: rtl/onchip_mem_arbiter.sv
// Two-master arbiter in front of a single-port byte-enabled on-chip RAM.
// Grants at most one access per cycle. The losing master is stalled with
// waitrequest. Read data comes back one cycle after the grant and is tagged
// with the owner's readdatavalid.
module onchip_mem_arbiter #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 32,
   parameter int BE_W       = 4,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] mem_address,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata
);

   typedef enum logic {
      M0 = 1'b0,
      M1 = 1'b1
   } master_e;

   master_e last_grant;
   master_e rd_owner;
   master_e winner;
   logic    rd_vld;
   logic    req0;
   logic    req1;
   logic    grant;
   logic    sel_write;

   // Pick the winner: a lone requester wins; on conflict m0 wins under fixed
   // priority, otherwise whichever master was not granted last.
   always_comb begin
      req0   = m0_read | m0_write;
      req1   = m1_read | m1_write;
      grant  = ~reset & (req0 | req1);
      winner = M0;
      if (req0 && req1) begin
         if (FIXED_PRIO || last_grant == M1) begin
            winner = M0;
         end else begin
            winner = M1;
         end
      end else if (req1) begin
         winner = M1;
      end
   end

   // Steer the granted master onto the RAM port; m0 drives it when idle.
   always_comb begin
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
      sel_write      = m0_write;
      if (grant && winner == M1) begin
         mem_address    = m1_address;
         mem_byteenable = m1_byteenable;
         mem_writedata  = m1_writedata;
         sel_write      = m1_write;
      end
   end

   assign mem_chipselect = grant;
   assign mem_write      = grant & sel_write;
   assign mem_clken      = 1'b1;

   assign m0_waitrequest = ~(grant && winner == M0);
   assign m1_waitrequest = ~(grant && winner == M1);

   // Track the last winner and the read issued this cycle for next-cycle return.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_vld     <= 1'b0;
         rd_owner   <= M0;
         last_grant <= M1;
      end else begin
         rd_vld <= grant & ~sel_write;
         if (grant) begin
            last_grant <= winner;
         end
         if (grant && !sel_write) begin
            rd_owner <= winner;
         end
      end
   end

   // rd_vld still holds a read granted just before reset rises, so the
   // strobe is also gated by reset to discard that response.
   assign m0_readdatavalid = rd_vld & ~reset & (rd_owner == M0);
   assign m1_readdatavalid = rd_vld & ~reset & (rd_owner == M1);
   assign m0_readdata      = mem_readdata;
   assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: a round-robin and a fixed-priority instance
// see the same master traffic, each behind its own behavioural RAM. The
// stimulus process predicts each cycle's handshake and read responses into
// queues, and a negedge monitor pops and compares them.
module tb_onchip_mem_arbiter;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;
   localparam int BE_W   = 4;

   typedef struct {
      int   cyc;
      logic w0;
      logic w1;
      logic cs;
      logic wr;
   } exp_t;

   typedef struct {
      int          due;
      int          owner;
      logic [31:0] data;
   } rsp_t;

   logic              clk = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] m0_address, m1_address;
   logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
   logic              m0_read, m1_read, m0_write, m1_write;
   logic [DATA_W-1:0] m0_writedata, m1_writedata;

   // Round-robin instance signals
   logic              rr_w0, rr_w1, rr_v0, rr_v1, rr_cs, rr_wr, rr_ck;
   logic [DATA_W-1:0] rr_d0, rr_d1, rr_wd, rr_rdata;
   logic [ADDR_W-1:0] rr_a;
   logic [BE_W-1:0]   rr_be;
   logic [DATA_W-1:0] ram_rr [1024];

   // Fixed-priority instance signals
   logic              fp_w0, fp_w1, fp_v0, fp_v1, fp_cs, fp_wr, fp_ck;
   logic [DATA_W-1:0] fp_d0, fp_d1, fp_wd, fp_rdata;
   logic [ADDR_W-1:0] fp_a;
   logic [BE_W-1:0]   fp_be;
   logic [DATA_W-1:0] ram_fp [1024];

   // Reference state, owned by the stimulus process
   logic [31:0] ref_mem [2][1024];
   int          last [2];
   int          cyc = 0;
   bit          done = 1'b0;
   exp_t        exp_q [2][$];
   rsp_t        rsp_q [2][$];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .FIXED_PRIO(1'b0)) u_rr (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(rr_w0),
      .m0_readdata(rr_d0), .m0_readdatavalid(rr_v0),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(rr_w1),
      .m1_readdata(rr_d1), .m1_readdatavalid(rr_v1),
      .mem_address(rr_a), .mem_byteenable(rr_be), .mem_chipselect(rr_cs),
      .mem_write(rr_wr), .mem_writedata(rr_wd), .mem_clken(rr_ck), .mem_readdata(rr_rdata)
   );

   onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .FIXED_PRIO(1'b1)) u_fp (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(fp_w0),
      .m0_readdata(fp_d0), .m0_readdatavalid(fp_v0),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(fp_w1),
      .m1_readdata(fp_d1), .m1_readdatavalid(fp_v1),
      .mem_address(fp_a), .mem_byteenable(fp_be), .mem_chipselect(fp_cs),
      .mem_write(fp_wr), .mem_writedata(fp_wd), .mem_clken(fp_ck), .mem_readdata(fp_rdata)
   );

   function automatic logic [31:0] init_word(input int i);
      if (i == 5) return 32'hDEADBEEF;
      if (i == 9) return 32'hAABBCCDD;
      return (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
   endfunction

   initial begin
      for (int i = 0; i < 1024; i++) begin
         ram_rr[i] <= init_word(i);
         ram_fp[i] <= init_word(i);
      end
   end

   // RAM models: one-cycle read latency, byte-enabled writes
   always @(posedge clk) begin
      if (rr_ck && rr_cs) begin
         if (rr_wr) begin
            for (int b = 0; b < BE_W; b++)
               if (rr_be[b]) ram_rr[rr_a][8*b +: 8] <= rr_wd[8*b +: 8];
         end else begin
            rr_rdata <= ram_rr[rr_a];
         end
      end
   end

   always @(posedge clk) begin
      if (fp_ck && fp_cs) begin
         if (fp_wr) begin
            for (int b = 0; b < BE_W; b++)
               if (fp_be[b]) ram_fp[fp_a][8*b +: 8] <= fp_wd[8*b +: 8];
         end else begin
            fp_rdata <= ram_fp[fp_a];
         end
      end
   end

   task automatic chk(input bit ok, input string name, input int g, input int c,
                      input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL %s inst%0d cycle %0d: got %h expected %h", name, g, c, act, req);
      end
   endtask

   task automatic mon(input int g, input logic w0, input logic w1, input logic cs,
                      input logic wr, input logic ck, input logic v0, input logic v1,
                      input logic [31:0] d0, input logic [31:0] d1);
      exp_t e;
      rsp_t r;
      bit   have;
      logic ev0, ev1;
      if (exp_q[g].size() == 0) return;
      e = exp_q[g].pop_front();
      chk(w0 === e.w0, "m0_waitrequest", g, e.cyc, 32'(w0), 32'(e.w0));
      chk(w1 === e.w1, "m1_waitrequest", g, e.cyc, 32'(w1), 32'(e.w1));
      chk(cs === e.cs, "mem_chipselect", g, e.cyc, 32'(cs), 32'(e.cs));
      chk(wr === e.wr, "mem_write", g, e.cyc, 32'(wr), 32'(e.wr));
      chk(ck === 1'b1, "mem_clken", g, e.cyc, 32'(ck), 32'd1);
      have = 1'b0;
      r    = '{due: 0, owner: 0, data: '0};
      if (rsp_q[g].size() > 0 && rsp_q[g][0].due == e.cyc) begin
         have = 1'b1;
         r    = rsp_q[g].pop_front();
      end
      ev0 = have && r.owner == 0;
      ev1 = have && r.owner == 1;
      chk(v0 === ev0, "m0_readdatavalid", g, e.cyc, 32'(v0), 32'(ev0));
      chk(v1 === ev1, "m1_readdatavalid", g, e.cyc, 32'(v1), 32'(ev1));
      if (ev0) chk(d0 === r.data, "m0_readdata", g, e.cyc, d0, r.data);
      if (ev1) chk(d1 === r.data, "m1_readdata", g, e.cyc, d1, r.data);
   endtask

   // Monitor: compare both instances every cycle, then summarise once drained
   always @(negedge clk) begin
      mon(0, rr_w0, rr_w1, rr_cs, rr_wr, rr_ck, rr_v0, rr_v1, rr_d0, rr_d1);
      mon(1, fp_w0, fp_w1, fp_cs, fp_wr, fp_ck, fp_v0, fp_v1, fp_d0, fp_d1);
      if (done && exp_q[0].size() == 0 && exp_q[1].size() == 0) begin
         for (int g = 0; g < 2; g++)
            chk(rsp_q[g].size() == 0, "undelivered_responses", g, cyc,
                32'(rsp_q[g].size()), 32'd0);
         $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
         $finish;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic set_m0(input logic rd, input logic wr, input int a, input logic [3:0] be,
                         input logic [31:0] d);
      m0_read = rd; m0_write = wr; m0_address = ADDR_W'(a); m0_byteenable = be; m0_writedata = d;
   endtask

   task automatic set_m1(input logic rd, input logic wr, input int a, input logic [3:0] be,
                         input logic [31:0] d);
      m1_read = rd; m1_write = wr; m1_address = ADDR_W'(a); m1_byteenable = be; m1_writedata = d;
   endtask

   task automatic idle_all();
      set_m0(1'b0, 1'b0, 0, 4'h0, 32'h0);
      set_m1(1'b0, 1'b0, 0, 4'h0, 32'h0);
   endtask

   // Predict this cycle's outcome for both instances, then advance one clock
   task automatic step();
      int          win;
      bit          r0, r1;
      logic [ADDR_W-1:0] a;
      logic [3:0]  be;
      logic [31:0] d;
      logic        w;
      exp_t        e;
      rsp_t        r;
      r0 = m0_read | m0_write;
      r1 = m1_read | m1_write;
      for (int g = 0; g < 2; g++) begin
         win = -1;
         if (reset) begin
            last[g] = 1;
            if (rsp_q[g].size() > 0 && rsp_q[g][$].due == cyc) void'(rsp_q[g].pop_back());
         end else if (r0 && r1) begin
            win = (g == 1) ? 0 : 1 - last[g];
         end else if (r0) begin
            win = 0;
         end else if (r1) begin
            win = 1;
         end
         e.cyc = cyc;
         e.w0  = (win != 0);
         e.w1  = (win != 1);
         e.cs  = (win >= 0);
         e.wr  = 1'b0;
         if (win >= 0) begin
            last[g] = win;
            if (win == 0) begin
               a = m0_address; be = m0_byteenable; d = m0_writedata; w = m0_write;
            end else begin
               a = m1_address; be = m1_byteenable; d = m1_writedata; w = m1_write;
            end
            e.wr = w;
            if (w) begin
               for (int b = 0; b < 4; b++)
                  if (be[b]) ref_mem[g][a][8*b +: 8] = d[8*b +: 8];
            end else begin
               r.due = cyc + 1; r.owner = win; r.data = ref_mem[g][a];
               rsp_q[g].push_back(r);
            end
         end
         exp_q[g].push_back(e);
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         ref_mem[0][i] = init_word(i);
         ref_mem[1][i] = init_word(i);
      end
      last[0] = 1;
      last[1] = 1;
      reset = 1'b1;
      idle_all();
      @(posedge clk);
      #1;
      step();
      step();
      reset = 1'b0;

      // single master read of preloaded word
      set_m0(1'b1, 1'b0, 5, 4'hF, 32'h0);
      step();
      idle_all();
      step();

      // byte-lane write by m1 then readback
      set_m1(1'b0, 1'b1, 9, 4'b0101, 32'h11223344);
      step();
      set_m1(1'b1, 1'b0, 9, 4'h0, 32'h0);
      step();
      idle_all();
      step();

      // conflict from a fresh reset, then m0 drops out
      reset = 1'b1;
      step();
      reset = 1'b0;
      set_m0(1'b1, 1'b0, 5, 4'hF, 32'h0);
      set_m1(1'b1, 1'b0, 9, 4'hF, 32'h0);
      repeat (6) step();
      set_m0(1'b0, 1'b0, 0, 4'h0, 32'h0);
      step();
      idle_all();
      step();

      // reset the cycle after a granted read, then a conflict
      set_m0(1'b1, 1'b0, 5, 4'hF, 32'h0);
      step();
      reset = 1'b1;
      set_m1(1'b1, 1'b0, 9, 4'hF, 32'h0);
      step();
      reset = 1'b0;
      repeat (2) step();
      idle_all();
      step();

      // read and write together act as a write, then read it back
      set_m0(1'b1, 1'b1, 7, 4'hF, 32'h5);
      step();
      idle_all();
      step();
      set_m0(1'b1, 1'b0, 7, 4'hF, 32'h0);
      step();
      idle_all();
      step();

      // random traffic on a small address window
      repeat (400) begin
         reset = ($urandom_range(0, 49) == 0);
         set_m0(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0),
                int'($urandom_range(0, 15)), 4'($urandom), $urandom);
         set_m1(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0),
                int'($urandom_range(0, 15)), 4'($urandom), $urandom);
         step();
      end
      reset = 1'b0;
      idle_all();
      repeat (3) step();
      done = 1'b1;
   end

endmodule
